// File: rtl/mux_pkg.sv
// Select codes, FSM encoding and small helpers shared by the round-robin
// arbiter and the downstream 3:1 mux.
package mux_pkg;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Everything the arbiter remembers apart from the hold counter, kept in one
    // place so a checker can observe it as a unit.
    typedef struct packed {
        state_t     state;
        logic [1:0] owner;
        logic [1:0] last_ptr;
    } arb_state_t;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            SEL_A:   oh = 3'b001;
            SEL_B:   oh = 3'b010;
            SEL_C:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_pick.sv
// Combinational round-robin picker: first set req bit scanning cyclically
// from last_ptr+1. valid=0 (idx=SEL_NONE) when nothing is requested.
module rr_pick3
    import mux_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_ptr,
    output logic       valid,
    output logic [1:0] idx
);

    // Scan order packed lowest-field-first: order[1:0] is checked first.
    logic [5:0] order;

    always_comb begin
        case (last_ptr)
            2'd0:    order = {SEL_A, SEL_C, SEL_B};
            2'd1:    order = {SEL_B, SEL_A, SEL_C};
            default: order = {SEL_C, SEL_B, SEL_A};
        endcase

        valid = 1'b1;
        if (req[order[1:0]]) begin
            idx = order[1:0];
        end else if (req[order[3:2]]) begin
            idx = order[3:2];
        end else if (req[order[5:4]]) begin
            idx = order[5:4];
        end else begin
            valid = 1'b0;
            idx   = SEL_NONE;
        end
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 3:1 mux; a grant is held
// until the owner drops req, strobes done, or the hold limit expires.
module mux3_rr_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD);

    // Handshake: req[i] is a level held by source i for as long as it wants the
    // mux; done is a single-cycle strobe from the current owner. A grant is
    // given on the edge after req is seen and is only taken away on release.
    arb_state_t       st;
    logic [CNT_W-1:0] hold_cnt;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] pick_ptr;
    logic       owner_req;
    logic       at_limit;
    logic       rel;

    // On release the pointer must already be the outgoing owner.
    assign pick_ptr  = (st.state == GRANT) ? st.owner : st.last_ptr;
    assign owner_req = |(req & grant);
    assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign rel       = done || !owner_req || at_limit;

    rr_pick3 u_pick (
        .req      (req),
        .last_ptr (pick_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st.state    <= IDLE;
            st.owner    <= SEL_A;
            st.last_ptr <= 2'd2;
            hold_cnt    <= '0;
            sel         <= SEL_NONE;
            grant       <= 3'b000;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (st.state)
                IDLE: begin
                    if (pick_valid) begin
                        st.state <= GRANT;
                        st.owner <= pick_idx;
                        hold_cnt <= '0;
                        sel      <= pick_idx;
                        grant    <= onehot3(pick_idx);
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        st.last_ptr <= st.owner;
                        timeout     <= at_limit && !done && owner_req;
                        hold_cnt    <= '0;
                        if (pick_valid) begin
                            st.owner <= pick_idx;
                            sel      <= pick_idx;
                            grant    <= onehot3(pick_idx);
                        end else begin
                            st.state <= IDLE;
                            sel      <= SEL_NONE;
                            grant    <= 3'b000;
                            busy     <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: st.state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter with MAX_HOLD=4: directed vector table followed by
// randomized traffic checked against a behavioural round-robin model.
module tb_mux3_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int N_VEC    = 31;
    localparam int N_RAND   = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       busy;
    logic       timeout;

    mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] req;
        logic       done;
        logic [1:0] sel;
        logic [2:0] grant;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t       vecs [N_VEC];
    logic [6:0] exp_q [$];
    int         checks = 0;
    int         passed = 0;

    // behavioural model: owner index or -1, cycles the grant has lasted so far
    int m_owner = -1;
    int m_last  = 2;
    int m_held  = 0;
    bit m_to    = 1'b0;

    function automatic vec_t v(input logic r, input logic [2:0] q, input logic d,
                               input logic [1:0] s, input logic [2:0] g,
                               input logic b, input logic t);
        vec_t x;
        x = '{rst: r, req: q, done: d, sel: s, grant: g, busy: b, timeout: t};
        return x;
    endfunction

    function automatic int m_pick(input logic [2:0] q, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (q[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [2:0] q, input logic d);
        int  w;
        bit  lim;
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = 2;
            m_held  = 0;
        end else if (m_owner < 0) begin
            w = m_pick(q, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else begin
            lim = (m_held == MAX_HOLD);
            if (d || !q[m_owner] || lim) begin
                m_to    = lim && !d && q[m_owner];
                m_last  = m_owner;
                m_owner = m_pick(q, m_last);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [1:0] s;
        logic [2:0] g;
        s = (m_owner < 0) ? 2'b11 : 2'(m_owner);
        g = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        return {s, g, (m_owner >= 0), m_to};
    endfunction

    // driver + scoreboard: apply inputs, clock once, compare against queue head
    task automatic step(input logic r, input logic [2:0] q, input logic d,
                        input logic [6:0] exp, input string name);
        logic [6:0] got;
        logic [6:0] e;
        rst  = r;
        req  = q;
        done = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {sel, grant, busy, timeout};
        e   = exp_q.pop_front();
        checks++;
        if (got === e) begin
            passed++;
        end else begin
            $display("FAIL %s: got sel=%b grant=%b busy=%b timeout=%b, expected sel=%b grant=%b busy=%b timeout=%b",
                     name, got[6:5], got[4:2], got[1], got[0], e[6:5], e[4:2], e[1], e[0]);
        end
    endtask

    initial begin
        logic [2:0] rq;
        logic       rr;
        logic       dd;

        rst  = 1'b1;
        req  = 3'b000;
        done = 1'b0;

        //                rst req    done sel    grant   busy timeout
        vecs[0]  = v(1'b1, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0); // reset
        vecs[1]  = v(1'b1, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0);
        vecs[2]  = v(1'b0, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0); // idle
        vecs[3]  = v(1'b0, 3'b010, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0); // single B
        vecs[4]  = v(1'b0, 3'b010, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0);
        vecs[5]  = v(1'b0, 3'b010, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0);
        vecs[6]  = v(1'b0, 3'b000, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0); // done, release
        vecs[7]  = v(1'b0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0); // A alone
        vecs[8]  = v(1'b0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[9]  = v(1'b0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[10] = v(1'b0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0); // 4th cycle
        vecs[11] = v(1'b0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 1'b1); // timeout, regrant A
        vecs[12] = v(1'b0, 3'b011, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[13] = v(1'b0, 3'b011, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[14] = v(1'b0, 3'b011, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[15] = v(1'b0, 3'b011, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1); // timeout -> B
        vecs[16] = v(1'b0, 3'b011, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0);
        vecs[17] = v(1'b0, 3'b111, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0); // non-owner C rises
        vecs[18] = v(1'b0, 3'b111, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0);
        vecs[19] = v(1'b0, 3'b111, 1'b1, 2'b10, 3'b100, 1'b1, 1'b0); // done at limit
        vecs[20] = v(1'b1, 3'b111, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0); // reset mid-grant
        vecs[21] = v(1'b0, 3'b111, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0); // A first
        vecs[22] = v(1'b0, 3'b111, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        vecs[23] = v(1'b0, 3'b111, 1'b1, 2'b01, 3'b010, 1'b1, 1'b0); // rotate to B
        vecs[24] = v(1'b0, 3'b111, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0);
        vecs[25] = v(1'b0, 3'b111, 1'b1, 2'b10, 3'b100, 1'b1, 1'b0); // rotate to C
        vecs[26] = v(1'b0, 3'b111, 1'b0, 2'b10, 3'b100, 1'b1, 1'b0);
        vecs[27] = v(1'b0, 3'b111, 1'b1, 2'b00, 3'b001, 1'b1, 1'b0); // rotate to A
        vecs[28] = v(1'b0, 3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0); // req drop
        vecs[29] = v(1'b0, 3'b000, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0); // done in idle
        vecs[30] = v(1'b0, 3'b100, 1'b0, 2'b10, 3'b100, 1'b1, 1'b0); // scan B,C,A -> C

        for (int i = 0; i < N_VEC; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done,
                 {vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].timeout},
                 $sformatf("vec%0d", i));
        end

        // randomized traffic against the model, starting from a clean reset
        model_step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0, model_out(), "rand_reset");
        rq = 3'b000;
        for (int i = 0; i < N_RAND; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
            dd = ($urandom_range(0, 6) == 0);
            model_step(rr, rq, dd);
            step(rr, rq, dd, model_out(), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
